// File: rtl/isr_vector_table_if.sv
// Bus bundle for the ISR vector table: register write/read port, interrupt
// request inputs, vector handshake to the core and configuration/error status.
interface isr_vector_table_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [NUM_CH-1:0] irq_req;
    logic              vec_valid;
    logic [DATA_W-1:0] vec_addr;
    logic [ID_W-1:0]   vec_id;
    logic              vec_ack;
    logic [NUM_CH-1:0] cfg_valid;
    logic              dec_error;
    logic [ADDR_W-1:0] err_addr;

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, irq_req, vec_ack,
        output rd_data, rd_valid, vec_valid, vec_addr, vec_id,
               cfg_valid, dec_error, err_addr
    );

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, irq_req, vec_ack,
        input  rd_data, rd_valid, vec_valid, vec_addr, vec_id,
               cfg_valid, dec_error, err_addr
    );
endinterface

// File: rtl/isr_vector_table.sv
// N-channel ISR vector table: memory-mapped ISR address registers, mask and
// status, latched interrupt requests and a lowest-index-first vector dispatcher.
module isr_vector_table #(
    parameter int                NUM_CH    = 4,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h00020000,
    parameter logic [31:0]       STRIDE    = 32'h00000020
) (
    input  logic                clk,
    input  logic                rst_n,
    isr_vector_table_if.slave   bus
);
    localparam int ID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STRIDE_SH = $clog2(STRIDE);
    localparam logic [ADDR_W-1:0] CH_SPAN    = ADDR_W'(NUM_CH * STRIDE);
    localparam logic [ADDR_W-1:0] STATUS_OFF = CH_SPAN + ADDR_W'(4);

    typedef enum logic [1:0] {
        D_NONE   = 2'd0,
        D_CH     = 2'd1,
        D_MASK   = 2'd2,
        D_STATUS = 2'd3
    } dec_kind_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Channel slots must be STRIDE-aligned; any other offset in the window is unmapped.
    function automatic dec_kind_t decode_kind(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] offset;
        offset = addr - BASE_ADDR;
        if ((offset < CH_SPAN) && (offset[STRIDE_SH-1:0] == {STRIDE_SH{1'b0}})) begin
            return D_CH;
        end else if (offset == CH_SPAN) begin
            return D_MASK;
        end else if (offset == STATUS_OFF) begin
            return D_STATUS;
        end else begin
            return D_NONE;
        end
    endfunction

    function automatic logic [ID_W-1:0] decode_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] offset;
        offset = addr - BASE_ADDR;
        return ID_W'(offset >> STRIDE_SH);
    endfunction

    logic [DATA_W-1:0] isr_r [NUM_CH];
    logic [NUM_CH-1:0] cfg_valid_r;
    logic [NUM_CH-1:0] mask_r;
    logic [NUM_CH-1:0] pending_r;
    logic              dec_error_r;
    logic [ADDR_W-1:0] err_addr_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    state_t            state_r;
    logic              vec_valid_r;
    logic [DATA_W-1:0] vec_addr_r;
    logic [ID_W-1:0]   vec_id_r;

    dec_kind_t         wr_kind_s;
    logic [ID_W-1:0]   wr_idx_s;
    dec_kind_t         rd_kind_s;
    logic [ID_W-1:0]   rd_idx_s;
    logic [DATA_W-1:0] rd_value_s;
    logic [NUM_CH-1:0] eligible_s;
    logic [ID_W-1:0]   low_idx_s;
    logic [NUM_CH-1:0] ack_clr_s;

    // Address decode for both ports.
    always_comb begin
        wr_kind_s = decode_kind(bus.wr_addr);
        wr_idx_s  = decode_idx(bus.wr_addr);
        rd_kind_s = decode_kind(bus.rd_addr);
        rd_idx_s  = decode_idx(bus.rd_addr);
    end

    // Read data mux; unmapped reads return zero.
    always_comb begin
        rd_value_s = {DATA_W{1'b0}};
        case (rd_kind_s)
            D_CH:     rd_value_s = isr_r[rd_idx_s];
            D_MASK:   rd_value_s[NUM_CH-1:0] = mask_r;
            D_STATUS: begin
                rd_value_s[NUM_CH-1:0] = pending_r;
                rd_value_s[31]         = dec_error_r;
            end
            default:  rd_value_s = {DATA_W{1'b0}};
        endcase
    end

    // Lowest-index eligible channel; scanning downward leaves the smallest index.
    always_comb begin
        eligible_s = pending_r & mask_r & cfg_valid_r;
        low_idx_s  = {ID_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            low_idx_s = eligible_s[i] ? ID_W'(i) : low_idx_s;
        end
    end

    // Pending clear mask from the core accepting the presented vector.
    always_comb begin
        ack_clr_s = {NUM_CH{1'b0}};
        if ((state_r == PRESENT) && bus.vec_ack) begin
            ack_clr_s[vec_id_r] = 1'b1;
        end else begin
            ack_clr_s = {NUM_CH{1'b0}};
        end
    end

    // Register file writes, mask, and sticky decode error with first-address capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                isr_r[i] <= {DATA_W{1'b0}};
            end
            cfg_valid_r <= {NUM_CH{1'b0}};
            mask_r      <= {NUM_CH{1'b1}};
            dec_error_r <= 1'b1;
            err_addr_r  <= {ADDR_W{1'b0}};
        end else if (bus.wr_en) begin
            case (wr_kind_s)
                D_CH: begin
                    isr_r[wr_idx_s]       <= bus.wr_data;
                    cfg_valid_r[wr_idx_s] <= 1'b1;
                end
                D_MASK: mask_r <= bus.wr_data[NUM_CH-1:0];
                D_STATUS: begin
                    dec_error_r <= 1'b0;
                    err_addr_r  <= {ADDR_W{1'b0}};
                end
                default: begin
                    if (!dec_error_r) begin
                        err_addr_r <= bus.wr_addr;
                    end
                    dec_error_r <= 1'b1;
                end
            endcase
        end
    end

    // Registered read port; sees pre-write contents on a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_r <= rd_value_s;
            end
        end
    end

    // Request latch; a new request on the ack edge keeps the channel pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {NUM_CH{1'b0}};
        end else begin
            pending_r <= (pending_r & ~ack_clr_s) | bus.irq_req;
        end
    end

    // Dispatcher FSM; the presented id/address are frozen until acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            vec_valid_r <= 1'b0;
            vec_addr_r  <= {DATA_W{1'b0}};
            vec_id_r    <= {ID_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (eligible_s != {NUM_CH{1'b0}}) begin
                        vec_id_r    <= low_idx_s;
                        vec_addr_r  <= isr_r[low_idx_s];
                        vec_valid_r <= 1'b1;
                        state_r     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.vec_ack) begin
                        vec_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    vec_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data   = rd_data_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.vec_valid = vec_valid_r;
    assign bus.vec_addr  = vec_addr_r;
    assign bus.vec_id    = vec_id_r;
    assign bus.cfg_valid = cfg_valid_r;
    assign bus.dec_error = dec_error_r;
    assign bus.err_addr  = err_addr_r;

endmodule

// File: tb/tb_isr_vector_table.sv
// Directed bench for isr_vector_table: register access, decode errors,
// dispatch order, masking, set-wins-over-ack and asynchronous reset.
module tb_isr_vector_table;
    localparam logic [31:0] CH0    = 32'h00020000;
    localparam logic [31:0] CH1    = 32'h00020020;
    localparam logic [31:0] CH2    = 32'h00020040;
    localparam logic [31:0] CH3    = 32'h00020060;
    localparam logic [31:0] MASK   = 32'h00020080;
    localparam logic [31:0] STATUS = 32'h00020084;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    isr_vector_table_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) bus ();

    isr_vector_table #(
        .NUM_CH(4), .ADDR_W(32), .DATA_W(32),
        .BASE_ADDR(32'h00020000), .STRIDE(32'h00000020)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        @(negedge clk);
        bus.rd_en   = 1'b0;
        chk({tag, "_valid"}, {31'd0, bus.rd_valid}, 32'd1);
        chk(tag, bus.rd_data, exp);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = 32'd0;
        bus.wr_data = 32'd0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = 32'd0;
        bus.irq_req = 4'd0;
        bus.vec_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_dec_error", {31'd0, bus.dec_error}, 32'd1);
        chk("rst_cfg_valid", {28'd0, bus.cfg_valid}, 32'd0);
        chk("rst_vec_valid", {31'd0, bus.vec_valid}, 32'd0);
        chk("rst_rd_valid",  {31'd0, bus.rd_valid},  32'd0);
        chk("rst_err_addr",  bus.err_addr, 32'd0);
        rd_chk("rst_mask", MASK, 32'h0000000F);

        wr(STATUS, 32'h12345678);
        chk("clr_dec_error", {31'd0, bus.dec_error}, 32'd0);
        chk("clr_err_addr",  bus.err_addr, 32'd0);
        rd_chk("status_clean", STATUS, 32'h00000000);

        wr(CH0, 32'h00001000);
        wr(CH1, 32'h00002000);
        wr(CH2, 32'h00003000);
        wr(CH3, 32'h00004000);
        chk("cfg_valid_all", {28'd0, bus.cfg_valid}, 32'h0000000F);
        rd_chk("rd_ch0", CH0, 32'h00001000);
        rd_chk("rd_ch1", CH1, 32'h00002000);
        rd_chk("rd_ch2", CH2, 32'h00003000);
        rd_chk("rd_ch3", CH3, 32'h00004000);
        @(negedge clk);
        chk("rd_valid_drop", {31'd0, bus.rd_valid}, 32'd0);
        rd_chk("rd_unmapped", 32'h00020004, 32'h00000000);
        chk("rd_unmapped_noerr", {31'd0, bus.dec_error}, 32'd0);

        wr(32'h00020010, 32'hDEADBEEF);
        chk("unaligned_dec_error", {31'd0, bus.dec_error}, 32'd1);
        chk("unaligned_err_addr",  bus.err_addr, 32'h00020010);
        wr(32'h00030000, 32'hCAFEF00D);
        chk("first_err_wins", bus.err_addr, 32'h00020010);
        rd_chk("status_err", STATUS, 32'h80000000);

        @(negedge clk);
        bus.irq_req = 4'b1010;
        @(negedge clk);
        bus.irq_req = 4'b0000;
        chk("vec_not_yet", {31'd0, bus.vec_valid}, 32'd0);
        @(negedge clk);
        chk("vec1_valid", {31'd0, bus.vec_valid}, 32'd1);
        chk("vec1_id",    {30'd0, bus.vec_id},    32'd1);
        chk("vec1_addr",  bus.vec_addr, 32'h00002000);
        bus.vec_ack = 1'b1;
        @(negedge clk);
        bus.vec_ack = 1'b0;
        chk("vec1_ack_low", {31'd0, bus.vec_valid}, 32'd0);
        @(negedge clk);
        chk("vec3_valid", {31'd0, bus.vec_valid}, 32'd1);
        chk("vec3_id",    {30'd0, bus.vec_id},    32'd3);
        chk("vec3_addr",  bus.vec_addr, 32'h00004000);
        bus.vec_ack = 1'b1;
        @(negedge clk);
        bus.vec_ack = 1'b0;
        chk("vec3_ack_low", {31'd0, bus.vec_valid}, 32'd0);

        wr(MASK, 32'h0000000D);
        @(negedge clk);
        bus.irq_req = 4'b0010;
        @(negedge clk);
        bus.irq_req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("masked_no_vec", {31'd0, bus.vec_valid}, 32'd0);
        rd_chk("status_pend1", STATUS, 32'h80000002);
        wr(MASK, 32'h0000000F);
        @(negedge clk);
        chk("unmask_valid", {31'd0, bus.vec_valid}, 32'd1);
        chk("unmask_id",    {30'd0, bus.vec_id},    32'd1);
        chk("unmask_addr",  bus.vec_addr, 32'h00002000);
        wr(CH1, 32'h00005555);
        chk("hold_addr",  bus.vec_addr, 32'h00002000);
        chk("hold_valid", {31'd0, bus.vec_valid}, 32'd1);
        rd_chk("rd_ch1_new", CH1, 32'h00005555);
        @(negedge clk);
        bus.vec_ack = 1'b1;
        @(negedge clk);
        bus.vec_ack = 1'b0;
        chk("unmask_ack_low", {31'd0, bus.vec_valid}, 32'd0);

        @(negedge clk);
        bus.irq_req = 4'b0001;
        @(negedge clk);
        bus.irq_req = 4'b0000;
        @(negedge clk);
        chk("vec0_valid", {31'd0, bus.vec_valid}, 32'd1);
        chk("vec0_id",    {30'd0, bus.vec_id},    32'd0);
        chk("vec0_addr",  bus.vec_addr, 32'h00001000);
        bus.vec_ack = 1'b1;
        bus.irq_req = 4'b0001;
        @(negedge clk);
        bus.vec_ack = 1'b0;
        bus.irq_req = 4'b0000;
        chk("vec0_ack_low", {31'd0, bus.vec_valid}, 32'd0);
        @(negedge clk);
        chk("vec0_re_valid", {31'd0, bus.vec_valid}, 32'd1);
        chk("vec0_re_id",    {30'd0, bus.vec_id},    32'd0);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vec_valid", {31'd0, bus.vec_valid}, 32'd0);
        chk("async_rst_dec_error", {31'd0, bus.dec_error}, 32'd1);
        chk("async_rst_cfg_valid", {28'd0, bus.cfg_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {31'd0, bus.vec_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
